dither_frame_sched: RTL

- Sequences an in-place Floyd-Steinberg dither pass over one grayscale frame held in an external pixel BRAM. The BRAM has two read ports and one write port.
- Each step reads the current-row right neighbour (b) and the next-row right neighbour (e), feeds the single-pixel dither datapath, and writes its diffused below-left result back to the BRAM.
- Sits between the capture frame buffer and the dither datapath. Owns row priming, per-row datapath reset, edge masking and write-back addressing.

---
 rtl/dither_frame_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dither_frame_sched.sv
// Row/step sequencer for an in-place Floyd-Steinberg pass over a frame held in a 2R/1W pixel BRAM.
// Issues B/E reads, strobes the dither datapath READ_LATENCY later and writes each result back to row y+1.
module dither_frame_sched #(
   parameter int WIDTH        = 320,
   parameter int HEIGHT       = 180,
   parameter int READ_LATENCY = 2,
   parameter int ADDR_W       = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   output logic              busy_out,
   output logic              done_out,
   output logic [ADDR_W-1:0] rd_addr_b_out,
   output logic [ADDR_W-1:0] rd_addr_e_out,
   input  logic [7:0]        rd_data_b_in,
   input  logic [7:0]        rd_data_e_in,
   output logic              dither_rst_out,
   output logic              a_valid_out,
   output logic [10:0]       a_hcount_out,
   output logic [9:0]        a_vcount_out,
   output logic [8:0]        b_out,
   output logic [8:0]        e_out,
   input  logic [7:0]        updated_pixel_in,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic [7:0]        wr_data_out
);

   typedef enum logic [1:0] {IDLE, ROW_RST, ISSUE, DRAIN} state_t;

   typedef struct packed {
      logic        valid;
      logic        mask_b;
      logic        mask_e;
      logic        wb;
      logic [10:0] hcount;
      logic [9:0]  vcount;
   } tag_t;

   localparam logic [10:0]       K_LAST   = 11'(WIDTH + 1);
   localparam logic [10:0]       K_HOLD   = 11'(WIDTH - 1);
   localparam logic [10:0]       K_MASK   = 11'(WIDTH);
   localparam logic [9:0]        Y_LAST   = 10'(HEIGHT - 1);
   localparam logic [2:0]        D_LAST   = 3'(READ_LATENCY);
   localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   logic [10:0]       k;
   logic [9:0]        y;
   logic [2:0]        drain_cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic              last_row;
   logic              next_last;
   tag_t              issue_tag;
   tag_t              pipe [READ_LATENCY];
   tag_t              dlv;

   assign last_row  = (y == Y_LAST);
   assign next_last = (10'(y + 10'd1) == Y_LAST);

   // Read addresses walk contiguously across rows: the held last column plus one is the next row base.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         k              <= '0;
         y              <= '0;
         drain_cnt      <= '0;
         busy_out       <= 1'b0;
         done_out       <= 1'b0;
         dither_rst_out <= 1'b0;
         rd_addr_b_out  <= '0;
         rd_addr_e_out  <= '0;
      end else begin
         done_out       <= 1'b0;
         dither_rst_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  state          <= ROW_RST;
                  busy_out       <= 1'b1;
                  dither_rst_out <= 1'b1;
                  y              <= '0;
                  rd_addr_b_out  <= '0;
                  rd_addr_e_out  <= (HEIGHT == 1) ? '0 : W_A;
               end
            end
            ROW_RST: begin
               state <= ISSUE;
               k     <= '0;
            end
            ISSUE: begin
               k <= k + 11'd1;
               if (k < K_HOLD) begin
                  rd_addr_b_out <= rd_addr_b_out + ADDR_ONE;
                  if (!last_row) rd_addr_e_out <= rd_addr_e_out + ADDR_ONE;
               end
               if (k == K_LAST) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 3'd1;
               if (drain_cnt == D_LAST) begin
                  if (last_row) begin
                     state    <= IDLE;
                     busy_out <= 1'b0;
                     done_out <= 1'b1;
                  end else begin
                     state          <= ROW_RST;
                     dither_rst_out <= 1'b1;
                     y              <= y + 10'd1;
                     rd_addr_b_out  <= rd_addr_b_out + ADDR_ONE;
                     if (!next_last) rd_addr_e_out <= rd_addr_e_out + ADDR_ONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: default the whole struct first so no field of the combinational tag can infer a latch.
   always_comb begin
      issue_tag = '0;
      if (state == ISSUE) begin
         issue_tag.valid  = 1'b1;
         issue_tag.mask_b = (k >= K_MASK);
         issue_tag.mask_e = (k >= K_MASK) || last_row;
         issue_tag.wb     = (k >= 11'd2) && !last_row;
         issue_tag.hcount = k - 11'd1;
         issue_tag.vcount = y;
      end
   end

   assign dlv = pipe[READ_LATENCY-1];

   // NOTE: the tag pipeline is reset (unlike a data memory) so no pending write-back survives rst_in.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
         wr_en_out   <= 1'b0;
         wr_addr_out <= '0;
         wr_ptr      <= '0;
      end else begin
         pipe[0] <= issue_tag;
         for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
         wr_en_out   <= dlv.wb;
         wr_addr_out <= dlv.wb ? wr_ptr : '0;
         // Write targets of consecutive rows are contiguous, starting at row 1.
         if (state == IDLE && start_in) wr_ptr <= W_A;
         else if (dlv.wb)               wr_ptr <= wr_ptr + ADDR_ONE;
      end
   end

   assign a_valid_out  = dlv.valid;
   assign a_hcount_out = dlv.hcount;
   assign a_vcount_out = dlv.vcount;
   assign b_out        = (dlv.valid && !dlv.mask_b) ? {1'b0, rd_data_b_in} : 9'd0;
   assign e_out        = (dlv.valid && !dlv.mask_e) ? {1'b0, rd_data_e_in} : 9'd0;
   assign wr_data_out  = wr_en_out ? updated_pixel_in : 8'd0;

endmodule
